div_unit: RTL

- Iterative 32-bit integer divider for the LoongArch32 core.
- Sits directly downstream of the register file. The dividend comes from the rj read port and the divisor from the rk read port.
- Produces a quotient or remainder plus a destination index and a write strobe. These feed the register file write port (wd/we, address rd).
- Handles div.w, mod.w, div.wu and mod.wu with a start/busy/done handshake.

---
 rtl/div_if.sv | 26 ++
 rtl/div_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Request/response bundle between the register-file read/write ports and div_unit.
interface div_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            cancel;
    logic [1:0]      op;
    logic [XLEN-1:0] src_j;
    logic [XLEN-1:0] src_k;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic            we_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] result;

    modport master (
        output start, cancel, op, src_j, src_k, rd_in,
        input  busy, done, we_out, rd_out, result
    );

    modport slave (
        input  start, cancel, op, src_j, src_k, rd_in,
        output busy, done, we_out, rd_out, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for div.w/mod.w/div.wu/mod.wu, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when divisor is 0 or |dividend| < |divisor|.
module div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic  clk,
    input logic  rstn,
    div_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;
    logic            mod_q;
    logic            sign_quo_q;
    logic            sign_rem_q;
    logic            div0_q;
    logic [4:0]      rd_lat_q;
    logic [4:0]      rd_out_q;

    logic            load;
    logic            step;
    logic            fin;
    logic            busy_c;
    logic            done_c;
    logic            early;

    // Operand magnitudes and signs; 0x80000000 maps to unsigned 2^31.
    logic            neg_j;
    logic            neg_k;
    logic [XLEN-1:0] mag_j;
    logic [XLEN-1:0] mag_k;
    logic            div0_in;

    assign neg_j   = ~bus.op[1] & bus.src_j[XLEN-1];
    assign neg_k   = ~bus.op[1] & bus.src_k[XLEN-1];
    assign mag_j   = neg_j ? XLEN'(0) - bus.src_j : bus.src_j;
    assign mag_k   = neg_k ? XLEN'(0) - bus.src_k : bus.src_k;
    assign div0_in = (bus.src_k == '0);

    // One restoring step; the 33-bit partial cannot overflow.
    logic [XLEN:0]   partial;
    logic            ge;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    assign partial = {rem_q, quo_q[XLEN-1]};
    assign ge      = (partial >= {1'b0, divisor_q});
    assign rem_nxt = ge ? XLEN'(partial - {1'b0, divisor_q}) : partial[XLEN-1:0];
    assign quo_nxt = {quo_q[XLEN-2:0], ge};

    function automatic logic [XLEN-1:0] fix_sign(input logic neg, input logic [XLEN-1:0] v);
        return neg ? XLEN'(0) - v : v;
    endfunction

    logic [XLEN-1:0] fin_val;
    assign fin_val = mod_q  ? fix_sign(sign_rem_q, rem_nxt) :
                     div0_q ? '1 : fix_sign(sign_quo_q, quo_nxt);

`ifdef DIV_EARLY_OUT_EN
    logic [XLEN-1:0] early_val;
    assign early     = div0_in || (mag_j < mag_k);
    assign early_val = bus.op[0] ? bus.src_j : (div0_in ? '1 : '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    state_d = early ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath controls and handshake outputs; done is gated by cancel in the same cycle.
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        fin    = 1'b0;
        done_c = 1'b0;
        busy_c = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: load = bus.start & ~bus.cancel;
            ST_CALC: begin
                step = ~bus.cancel;
                fin  = ~bus.cancel & (cnt_q == CNT_W'(1));
            end
            ST_DONE: done_c = ~bus.cancel;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            mod_q      <= 1'b0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            div0_q     <= 1'b0;
            rd_lat_q   <= '0;
            rd_out_q   <= '0;
            result_q   <= '0;
        end else begin
            if (load) begin
                mod_q      <= bus.op[0];
                sign_quo_q <= neg_j ^ neg_k;
                sign_rem_q <= neg_j;
                div0_q     <= div0_in;
                divisor_q  <= mag_k;
                quo_q      <= mag_j;
                rem_q      <= '0;
                cnt_q      <= CNT_W'(XLEN);
                rd_lat_q   <= bus.rd_in;
`ifdef DIV_EARLY_OUT_EN
                if (early) begin
                    result_q <= early_val;
                    rd_out_q <= bus.rd_in;
                end
`endif
            end
            if (step) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (fin) begin
                result_q <= fin_val;
                rd_out_q <= rd_lat_q;
            end
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.we_out = done_c;
    assign bus.rd_out = rd_out_q;
    assign bus.result = result_q;

endmodule
